// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the 1-D convolution engine:
//   conv_state_t  : controller state encoding
//   SHAPE_FULL/SAME : encoding of the shape input
// -----------------------------------------------------------------------------
package conv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT  = 3'd1,
      ST_JSET  = 3'd2,
      ST_READ  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_WRITE = 3'd5,
      ST_DONE  = 3'd6
   } conv_state_t;

   localparam logic SHAPE_FULL = 1'b0;
   localparam logic SHAPE_SAME = 1'b1;

endpackage

// File: rtl/conv1d_engine_if.sv
// -----------------------------------------------------------------------------
// conv1d_engine_if
// Register-side handshake and X/Y/Z memory bus of the convolution engine.
//   start, shape, size_x, size_y : job request (from register block)
//   busy, done                   : job status (to register block)
//   x_addr/x_data, y_addr/y_data : synchronous-read operand memories
//   z_addr/z_data/z_we           : result memory write port
// Modports:
//   master : the engine
//   slave  : register block + memories
// -----------------------------------------------------------------------------
interface conv1d_engine_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int Z_W    = 16
);
   logic              start;
   logic              shape;
   logic [ADDR_W-1:0] size_x;
   logic [ADDR_W-1:0] size_y;
   logic [ADDR_W-1:0] x_addr;
   logic [DATA_W-1:0] x_data;
   logic [ADDR_W-1:0] y_addr;
   logic [DATA_W-1:0] y_data;
   logic [ADDR_W:0]   z_addr;
   logic [Z_W-1:0]    z_data;
   logic              z_we;
   logic              busy;
   logic              done;

   modport master (
      input  start, shape, size_x, size_y, x_data, y_data,
      output x_addr, y_addr, z_addr, z_data, z_we, busy, done
   );

   modport slave (
      output start, shape, size_x, size_y, x_data, y_data,
      input  x_addr, y_addr, z_addr, z_data, z_we, busy, done
   );

endinterface

// File: rtl/conv_mac.sv
// -----------------------------------------------------------------------------
// conv_mac
// Signed multiply-accumulate with clear, plus the Z_W output reduction.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : zero the accumulator (start of a new output sample)
//   vld_p1   : x_p1/y_p1 hold a valid operand pair this cycle
//   x_p1,y_p1: signed operands (memory read data)
//   z_out    : accumulator reduced to Z_W bits
// Build option CONV_SATURATE_EN: clamp to the Z_W signed range instead of
// keeping the Z_W LSBs.
// -----------------------------------------------------------------------------
module conv_mac #(
   parameter int DATA_W = 8,
   parameter int Z_W    = 16,
   parameter int ACC_W  = 2*DATA_W + 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     vld_p1,
   input  logic signed [DATA_W-1:0] x_p1,
   input  logic signed [DATA_W-1:0] y_p1,
   output logic signed [Z_W-1:0]    z_out
);

   logic signed [2*DATA_W-1:0] x_ext_p1;
   logic signed [2*DATA_W-1:0] y_ext_p1;
   logic signed [2*DATA_W-1:0] prod_p1;
   logic signed [ACC_W-1:0]    prod_ext_p1;
   logic signed [ACC_W-1:0]    acc_p2;

   // stage p1: operands arrive from memory, full-precision signed product
   assign x_ext_p1    = {{DATA_W{x_p1[DATA_W-1]}}, x_p1};
   assign y_ext_p1    = {{DATA_W{y_p1[DATA_W-1]}}, y_p1};
   assign prod_p1     = x_ext_p1 * y_ext_p1;
   assign prod_ext_p1 = {{(ACC_W-2*DATA_W){prod_p1[2*DATA_W-1]}}, prod_p1};

   // stage p2: accumulator
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_p2 <= '0;
      end else if (clr) begin
         acc_p2 <= '0;
      end else if (vld_p1) begin
         acc_p2 <= acc_p2 + prod_ext_p1;
      end
   end

`ifdef CONV_SATURATE_EN
   localparam logic signed [ACC_W-1:0] ZMAX = ACC_W'(2**(Z_W-1) - 1);
   localparam logic signed [ACC_W-1:0] ZMIN = ~ZMAX;

   function automatic logic signed [Z_W-1:0] sat_z(input logic signed [ACC_W-1:0] a);
      if (a > ZMAX)
         return ZMAX[Z_W-1:0];
      else if (a < ZMIN)
         return ZMIN[Z_W-1:0];
      else
         return a[Z_W-1:0];
   endfunction

   assign z_out = sat_z(acc_p2);
`else
   function automatic logic signed [Z_W-1:0] wrap_z(input logic signed [ACC_W-1:0] a);
      return a[Z_W-1:0];
   endfunction

   assign z_out = wrap_z(acc_p2);
`endif

endmodule

// File: rtl/conv1d_engine.sv
// -----------------------------------------------------------------------------
// conv1d_engine
// 1-D convolution Z[k] = sum_j X[j]*Y[k-j] over external synchronous-read
// memories. Controller (FSM + index counters) lives here, the MAC and output
// reduction live in conv_mac.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : conv1d_engine_if.master (start/shape/sizes/busy/done, X/Y/Z ports)
// Build option CONV_SATURATE_EN (in conv_mac): saturate instead of wrap.
// -----------------------------------------------------------------------------
module conv1d_engine
   import conv_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int Z_W    = 16,
   parameter int ACC_W  = 2*DATA_W + ADDR_W
) (
   input  logic             clk,
   input  logic             rst,
   conv1d_engine_if.master  bus
);

   conv_state_t state, state_nxt;

   logic [ADDR_W-1:0] sx_r, sy_r, off_r;
   logic              shape_r;
   logic [ADDR_W:0]   k_r, kend_r;
   logic [ADDR_W-1:0] j_r, jmax_r;
   logic              vld_p1;
   logic              acc_clr;
   logic signed [Z_W-1:0] z_mac;

   logic [ADDR_W:0]   sx_e, sy_e, off_e, k_inc;
   logic [ADDR_W-1:0] off_c, jmin_c, jmax_c;
   logic [ADDR_W:0]   kstart_c, kend_c;
   logic              size_zero;

   // ---------------------------------------------------------------------
   // Index arithmetic. k may exceed the ADDR_W range (full shape reaches
   // size_x+size_y-2), so k-related values carry one extra bit.
   // ---------------------------------------------------------------------
   assign sx_e  = {1'b0, sx_r};
   assign sy_e  = {1'b0, sy_r};
   assign off_e = {1'b0, off_r};
   assign k_inc = k_r + (ADDR_W+1)'(1);

   assign size_zero = (sx_r == '0) || (sy_r == '0);
   assign off_c     = (sx_r - ADDR_W'(1)) >> 1;

   assign kstart_c = (shape_r == SHAPE_SAME) ? {1'b0, off_c} : '0;
   assign kend_c   = (shape_r == SHAPE_SAME) ? ({1'b0, off_c} + sy_e - (ADDR_W+1)'(1))
                                             : (sx_e + sy_e - (ADDR_W+1)'(2));

   // jmin = max(0, k-size_y+1), jmax = min(k, size_x-1)
   assign jmin_c = (k_inc > sy_e) ? ADDR_W'(k_inc - sy_e) : '0;
   assign jmax_c = (k_r < sx_e) ? ADDR_W'(k_r) : (sx_r - ADDR_W'(1));

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (bus.start) state_nxt = ST_INIT;
         ST_INIT:  state_nxt = size_zero ? ST_DONE : ST_JSET;
         ST_JSET:  state_nxt = ST_READ;
         ST_READ:  if (j_r == jmax_r) state_nxt = ST_DRAIN;
         ST_DRAIN: state_nxt = ST_WRITE;
         ST_WRITE: state_nxt = (k_r == kend_r) ? ST_DONE : ST_JSET;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs. Addresses and write data are forced to zero outside the
   // states that use them so the bus is quiet between accesses.
   // ---------------------------------------------------------------------
   always_comb begin
      bus.busy   = 1'b0;
      bus.done   = 1'b0;
      bus.z_we   = 1'b0;
      bus.x_addr = '0;
      bus.y_addr = '0;
      bus.z_addr = '0;
      bus.z_data = '0;
      acc_clr    = 1'b0;
      case (state)
         ST_INIT:  bus.busy = 1'b1;
         ST_JSET: begin
            bus.busy = 1'b1;
            acc_clr  = 1'b1;
         end
         ST_READ: begin
            bus.busy   = 1'b1;
            bus.x_addr = j_r;
            bus.y_addr = ADDR_W'(k_r - {1'b0, j_r});
         end
         ST_DRAIN: bus.busy = 1'b1;
         ST_WRITE: begin
            bus.busy   = 1'b1;
            bus.z_we   = 1'b1;
            bus.z_addr = k_r - ((shape_r == SHAPE_SAME) ? off_e : '0);
            bus.z_data = z_mac;
         end
         ST_DONE:  bus.done = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Job parameters and index counters
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sx_r    <= '0;
         sy_r    <= '0;
         shape_r <= SHAPE_FULL;
         off_r   <= '0;
         k_r     <= '0;
         kend_r  <= '0;
         j_r     <= '0;
         jmax_r  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  sx_r    <= bus.size_x;
                  sy_r    <= bus.size_y;
                  shape_r <= bus.shape;
               end
            end
            ST_INIT: begin
               k_r    <= kstart_c;
               kend_r <= kend_c;
               off_r  <= off_c;
            end
            ST_JSET: begin
               j_r    <= jmin_c;
               jmax_r <= jmax_c;
            end
            ST_READ:  j_r <= j_r + ADDR_W'(1);
            ST_WRITE: k_r <= k_inc;
            default: ;
         endcase
      end
   end

   // stage p0 -> p1: an address issued in READ returns data one cycle later
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         vld_p1 <= 1'b0;
      else
         vld_p1 <= (state == ST_READ);
   end

   conv_mac #(
      .DATA_W (DATA_W),
      .Z_W    (Z_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk    (clk),
      .rst    (rst),
      .clr    (acc_clr),
      .vld_p1 (vld_p1),
      .x_p1   ($signed(bus.x_data)),
      .y_p1   ($signed(bus.y_data)),
      .z_out  (z_mac)
   );

endmodule

// File: tb/tb_conv1d_engine.sv
// -----------------------------------------------------------------------------
// tb_conv1d_engine
// Two engine instances (Z_W=16 and Z_W=8) sharing one X/Y memory image.
// Expected Z writes come from a direct convolution model and are queued at
// job launch; a monitor pops and compares them on every z_we.
// -----------------------------------------------------------------------------
module tb_conv1d_engine;
   import conv_pkg::*;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 5;
   localparam int TMO    = 2000;

   typedef struct {
      int addr;
      int data;
   } sb_t;

   logic clk = 1'b0;
   logic rst;

   logic signed [DATA_W-1:0] xmem [32];
   logic signed [DATA_W-1:0] ymem [32];

   sb_t q16 [$];
   sb_t q8  [$];

   int n_checks = 0;
   int n_errors = 0;

   conv1d_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .Z_W(16)) bus16 ();
   conv1d_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .Z_W(8))  bus8 ();

   conv1d_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .Z_W(16)) u_dut16 (
      .clk (clk),
      .rst (rst),
      .bus (bus16)
   );

   conv1d_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .Z_W(8)) u_dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   always #5 clk = ~clk;

   // synchronous-read memories
   always @(posedge clk) begin
      bus16.x_data <= xmem[bus16.x_addr];
      bus16.y_data <= ymem[bus16.y_addr];
      bus8.x_data  <= xmem[bus8.x_addr];
      bus8.y_data  <= ymem[bus8.y_addr];
   end

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int reduce(input int acc, input int zw);
      int r = acc;
`ifdef CONV_SATURATE_EN
      int hi = (1 << (zw-1)) - 1;
      int lo = -(1 << (zw-1));
      if (r > hi) r = hi;
      else if (r < lo) r = lo;
`endif
      return r & ((1 << zw) - 1);
   endfunction

   // Direct convolution model; queues the expected writes, returns busy length
   task automatic model(input bit d8, input bit shp, input int sx, input int sy,
                        output int busy_exp);
      int off, kmin, kmax, acc, len;
      sb_t e;
      busy_exp = 1;
      if (sx == 0 || sy == 0) return;
      off  = (sx - 1) >> 1;
      kmin = shp ? off : 0;
      kmax = shp ? off + sy - 1 : sx + sy - 2;
      for (int k = kmin; k <= kmax; k++) begin
         acc = 0;
         len = 0;
         for (int j = 0; j < sx; j++) begin
            if (k - j >= 0 && k - j < sy) begin
               acc += int'(xmem[j]) * int'(ymem[k-j]);
               len++;
            end
         end
         busy_exp += len + 3;
         e.addr = k - (shp ? off : 0);
         e.data = reduce(acc, d8 ? 8 : 16);
         if (d8) q8.push_back(e);
         else    q16.push_back(e);
      end
   endtask

   function automatic logic get_busy(input bit d8);
      return d8 ? bus8.busy : bus16.busy;
   endfunction

   function automatic logic get_done(input bit d8);
      return d8 ? bus8.done : bus16.done;
   endfunction

   function automatic int q_size(input bit d8);
      return d8 ? q8.size() : q16.size();
   endfunction

   task automatic set_start(input bit d8, input logic v);
      if (d8) bus8.start = v;
      else    bus16.start = v;
   endtask

   task automatic set_job(input bit d8, input bit shp, input int sx, input int sy);
      if (d8) begin
         bus8.shape  = shp;
         bus8.size_x = ADDR_W'(sx);
         bus8.size_y = ADDR_W'(sy);
      end else begin
         bus16.shape  = shp;
         bus16.size_x = ADDR_W'(sx);
         bus16.size_y = ADDR_W'(sy);
      end
   endtask

   // Launch one job; dup_at > 0 raises start again during that busy cycle
   task automatic run_job(input bit d8, input bit shp, input int sx, input int sy,
                          input int dup_at, input string tag);
      int  busy_exp, busy_n;
      bit  ended, done_ok;
      model(d8, shp, sx, sy, busy_exp);
      @(negedge clk);
      set_job(d8, shp, sx, sy);
      set_start(d8, 1'b1);
      @(negedge clk);
      set_start(d8, 1'b0);
      busy_n  = 0;
      ended   = 0;
      done_ok = 0;
      for (int c = 0; c < TMO && !ended; c++) begin
         if (get_busy(d8)) begin
            busy_n++;
            if (busy_n == dup_at) set_start(d8, 1'b1);
            @(negedge clk);
            set_start(d8, 1'b0);
         end else begin
            ended   = 1;
            done_ok = get_done(d8);
         end
      end
      check_val({tag, "_terminated"}, int'(ended), 1);
      check_val({tag, "_busy_cycles"}, busy_n, busy_exp);
      check_val({tag, "_done"}, int'(done_ok), 1);
      @(negedge clk);
      check_val({tag, "_done_width"}, int'(get_done(d8)), 0);
      check_val({tag, "_pending_writes"}, q_size(d8), 0);
      if (d8) q8.delete();
      else    q16.delete();
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin : mon
      sb_t e;
      if (bus16.z_we === 1'b1) begin
         if (q16.size() == 0) begin
            check_val("z16_unexpected_we", 1, 0);
         end else begin
            e = q16.pop_front();
            check_val("z16_addr", int'(bus16.z_addr), e.addr);
            check_val("z16_data", int'(bus16.z_data), e.data);
         end
      end
      if (bus8.z_we === 1'b1) begin
         if (q8.size() == 0) begin
            check_val("z8_unexpected_we", 1, 0);
         end else begin
            e = q8.pop_front();
            check_val("z8_addr", int'(bus8.z_addr), e.addr);
            check_val("z8_data", int'(bus8.z_data), e.data);
         end
      end
   end

   task automatic load_default();
      for (int i = 0; i < 32; i++) begin
         xmem[i] = '0;
         ymem[i] = '0;
      end
      xmem[0] = 1; xmem[1] = 2; xmem[2] = 3;
      ymem[0] = 1; ymem[1] = 1; ymem[2] = 1; ymem[3] = 1;
   endtask

   initial begin
      int eb;
      rst = 1'b1;
      bus16.start = 1'b0; bus8.start = 1'b0;
      set_job(0, SHAPE_FULL, 0, 0);
      set_job(1, SHAPE_FULL, 0, 0);
      load_default();

      repeat (3) @(negedge clk);
      check_val("rst_busy",   int'(bus16.busy),   0);
      check_val("rst_done",   int'(bus16.done),   0);
      check_val("rst_z_we",   int'(bus16.z_we),   0);
      check_val("rst_x_addr", int'(bus16.x_addr), 0);
      check_val("rst_y_addr", int'(bus16.y_addr), 0);
      check_val("rst_z_addr", int'(bus16.z_addr), 0);
      check_val("rst_z_data", int'(bus16.z_data), 0);
      rst = 1'b0;
      @(negedge clk);

      // full and same shapes on the test-plan data
      run_job(0, SHAPE_FULL, 3, 4, 0, "full");
      run_job(0, SHAPE_SAME, 3, 4, 0, "same");
      run_job(0, SHAPE_SAME, 4, 5, 0, "same_even");

      // degenerate sizes
      run_job(0, SHAPE_FULL, 0, 4, 0, "zero_x");
      run_job(0, SHAPE_SAME, 3, 0, 0, "zero_y");

      // start raised while busy must be ignored
      run_job(0, SHAPE_FULL, 3, 4, 5,  "dup_start_mid");
      run_job(0, SHAPE_FULL, 3, 4, 31, "dup_start_last");

      // reduction to Z_W=8
      xmem[0] = 127;  ymem[0] = 127;
      run_job(1, SHAPE_FULL, 1, 1, 0, "sat_pos");
      xmem[0] = -128; ymem[0] = 127;
      run_job(1, SHAPE_FULL, 1, 1, 0, "sat_neg");

      // mixed-sign random data on both widths
      for (int i = 0; i < 8; i++) begin
         xmem[i] = DATA_W'($urandom_range(0, 255));
         ymem[i] = DATA_W'($urandom_range(0, 255));
      end
      run_job(0, SHAPE_FULL, 5, 7, 0, "rand_full16");
      run_job(1, SHAPE_SAME, 6, 8, 0, "rand_same8");
      load_default();

      // reset during READ of k=2
      model(0, SHAPE_FULL, 3, 4, eb);
      @(negedge clk);
      set_job(0, SHAPE_FULL, 3, 4);
      bus16.start = 1'b1;
      @(negedge clk);
      bus16.start = 1'b0;
      repeat (12) @(negedge clk);
      check_val("rstjob_pre_busy",   int'(bus16.busy),   1);
      check_val("rstjob_pre_x_addr", int'(bus16.x_addr), 1);
      check_val("rstjob_pre_y_addr", int'(bus16.y_addr), 1);
      rst = 1'b1;
      #1;
      check_val("rstjob_busy",   int'(bus16.busy),   0);
      check_val("rstjob_z_we",   int'(bus16.z_we),   0);
      check_val("rstjob_x_addr", int'(bus16.x_addr), 0);
      check_val("rstjob_y_addr", int'(bus16.y_addr), 0);
      check_val("rstjob_done",   int'(bus16.done),   0);
      check_val("rstjob_writes_left", q16.size(), 4);
      q16.delete();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_val("rstjob_hold_done", int'(bus16.done), 0);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("rstjob_after_done", int'(bus16.done), 0);
         check_val("rstjob_after_busy", int'(bus16.busy), 0);
      end
      run_job(0, SHAPE_FULL, 3, 4, 0, "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/conv1d_engine.md
# conv1d_engine

Parametrised 1-D convolution engine for the convolution IP, computing Z[k] = Σ X[j]·Y[k−j] over signed operands held in external synchronous-read memories. It merges the controller and the datapath into one block: sequencing, index generation, multiply-accumulate and result write-back. Two shapes are supported: full and same. It sits between the IP register interface (start, sizes, shape, busy, done) and the three local memories X, Y and Z.

## Interface
- DATA_W, 8, operand width of X and Y (signed)
- ADDR_W, 5, memory address width; sizes range 0..2^ADDR_W−1
- Z_W, 16, result word width written to Z
- ACC_W, 2*DATA_W+ADDR_W, internal accumulator width
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a job; sampled only in IDLE
- shape  in  1  0 = full, 1 = same; latched at start
- size_x  in  ADDR_W  length of X (kernel); latched at start
- size_y  in  ADDR_W  length of Y (signal); latched at start
- x_addr  out  ADDR_W  X read address
- x_data  in  DATA_W  X read data, valid one cycle after x_addr
- y_addr  out  ADDR_W  Y read address
- y_data  in  DATA_W  Y read data, valid one cycle after y_addr
- z_addr  out  ADDR_W+1  Z write address
- z_data  out  Z_W  Z write data
- z_we  out  1  Z write strobe, one cycle per result
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse

## Operation
- Reset values: all outputs 0; state IDLE; counters and accumulator cleared.
- States: IDLE, INIT, JSET, READ, DRAIN, WRITE, DONE.
- IDLE: start=1 → latch sizes and shape, go to INIT. start outside IDLE is ignored.
- INIT: if size_x=0 or size_y=0 → DONE (no writes). Otherwise set the k range and go to JSET:
  - full: k = 0..size_x+size_y−2
  - same: off = (size_x−1)>>1; k = off..off+size_y−1
- JSET: jmin = max(0, k−size_y+1), jmax = min(k, size_x−1); clear the accumulator; go to READ.
- READ: issue x_addr=j, y_addr=k−j for j = jmin..jmax, one per cycle. The accumulator adds x_data·y_data (signed, ACC_W) one cycle after each issue. After jmax, go to DRAIN.
- DRAIN: final MAC; go to WRITE.
- WRITE: z_we=1, z_addr=k−(full ? 0 : off), z_data=accumulator reduced to Z_W (see Configuration). Next k exists → JSET; otherwise → DONE.
- DONE: done=1, busy=0; → IDLE.
- busy=1 in INIT through WRITE.
- Reset mid-job: immediate return to IDLE, z_we=0, no further writes, no done pulse.

## Timing
- Per output: L_k + 3 cycles, where L_k = jmax−jmin+1 (JSET, L_k READ, DRAIN, WRITE).
- busy spans 1 + Σ(L_k+3) cycles. done is high in the cycle after the last WRITE.
- The cycle after start is sampled is INIT. A new start is accepted in the cycle after done.

## Configuration
- CONV_SATURATE_EN defined: the accumulator is clamped to [−2^(Z_W−1), 2^(Z_W−1)−1] before the Z write.
- Not defined: the Z_W LSBs are written (two's-complement wrap).

## Structure
- Shared package conv_pkg holds:
  - state enum type
  - shape constants SHAPE_FULL=0, SHAPE_SAME=1
- Sub-module conv_mac holds the signed multiply, accumulator (clear/enable) and the saturate/wrap output stage. The top holds the FSM and index counters.

## Test plan
- Full: DATA_W=8, Z_W=16; X={1,2,3}, Y={1,1,1,1}, shape=0 → writes Z[0..5]={1,3,6,6,5,3}; busy high 31 cycles; done 1 cycle later.
- Same: same data, shape=1 → writes Z[0..3]={3,6,6,5} to addresses 0..3; no other z_we.
- Saturation: Z_W=8; X={127}, Y={127} → z_data=127 with CONV_SATURATE_EN, 8'h01 without. X={−128}, Y={127} → −128 with CONV_SATURATE_EN, 8'h80 without.
- Zero size: size_x=0 → no z_we; busy 1 cycle (INIT); done pulse follows.
- Start while busy: second start during a job is ignored; result and done timing are identical to the single-start case.
- Reset mid-job: rst asserted during READ of k=2 → outputs 0 asynchronously; no done. A fresh start afterwards gives the correct full result.
